// File: rtl/decoder_2x4_seq.sv
// decoder_2x4_seq: registered 2-to-4 decoder with valid/ready handshake and programmable hold time
// Ports: clk; rst_n (async, active-low); a[1:0] encoded index; valid/ready transfer handshake;
//        y[3:0] registered one-hot output (0 when idle); busy registered, equals (y != 0).
// Optional: define DECODER_2X4_GAP_EN to insert one forced zero GAP clock after every hold period.
module decoder_2x4_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic       valid,
  output logic       ready,
  output logic [3:0] y,
  output logic       busy
);
`ifdef DECODER_2X4_GAP_EN
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
`else
  typedef enum logic {IDLE, DRIVE} state_t;
`endif
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       y_n;
  logic             busy_n, last, xfer;
  assign last = cnt == '0;
`ifdef DECODER_2X4_GAP_EN
  assign ready = state == IDLE;
`else
  // cnt is 0 in IDLE, so this is also the final-drive-cycle reload window
  assign ready = state == IDLE || last;
`endif
  assign xfer = valid && ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      y     <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      y     <= y_n;
      busy  <= busy_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = last ? cnt : cnt - CNT_W'(1);
    y_n     = y;
    busy_n  = busy;
    if (xfer) begin
      state_n = DRIVE;
      cnt_n   = CNT_W'(HOLD_CYCLES - 1);
      y_n     = 4'b0001 << a;
      busy_n  = 1'b1;
    end else if (state == DRIVE && last) begin
      y_n     = '0;
      busy_n  = 1'b0;
`ifdef DECODER_2X4_GAP_EN
      state_n = GAP;
    end else if (state == GAP) begin
      state_n = IDLE;
`else
      state_n = IDLE;
`endif
    end
  end
endmodule

// File: tb/tb_decoder_2x4_seq.sv
// tb_decoder_2x4_seq: random + directed bench for decoder_2x4_seq (HOLD_CYCLES=4 and =1 instances)
module tb_decoder_2x4_seq;
  logic       clk, rst_n, valid;
  logic [1:0] a;
  logic [3:0] y4, y1;
  logic       ready4, ready1, busy4, busy1;
  int         total = 0, bad = 0;

  decoder_2x4_seq #(.HOLD_CYCLES(4), .CNT_W(8)) d4 (
    .clk(clk), .rst_n(rst_n), .a(a), .valid(valid), .ready(ready4), .y(y4), .busy(busy4));
  decoder_2x4_seq #(.HOLD_CYCLES(1), .CNT_W(8)) d1 (
    .clk(clk), .rst_n(rst_n), .a(a), .valid(valid), .ready(ready1), .y(y1), .busy(busy1));

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference: per instance, the word currently shown, how many clocks it still has
  // to be shown (including the present one), and a pending forced-zero clock.
  int         hold [2] = '{4, 1};
  int         left [2];
  int         gap  [2];
  logic [3:0] my   [2];

  function automatic bit mready(int k);
`ifdef DECODER_2X4_GAP_EN
    return left[k] == 0 && gap[k] == 0;
`else
    return left[k] <= 1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        left[k] = 0;
        gap[k]  = 0;
        my[k]   = 4'b0000;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (valid && mready(k)) begin
          my[k]   = 4'(1 << a);
          left[k] = hold[k];
        end else if (left[k] > 0) begin
          left[k] = left[k] - 1;
          if (left[k] == 0) begin
            my[k] = 4'b0000;
`ifdef DECODER_2X4_GAP_EN
            gap[k] = 1;
`endif
          end
        end else gap[k] = 0;
      end
    end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("y4", y4, my[0]);
    chk("busy4", {3'b0, busy4}, {3'b0, my[0] != 0});
    chk("ready4", {3'b0, ready4}, {3'b0, mready(0)});
    chk("y1", y1, my[1]);
    chk("busy1", {3'b0, busy1}, {3'b0, my[1] != 0});
    chk("ready1", {3'b0, ready1}, {3'b0, mready(1)});
  end

  task automatic step(input logic v, input logic [1:0] aa);
    @(negedge clk);
    #1;
    valid = v;
    a = aa;
  endtask

  logic [3:0] exp3 [10];

  initial begin
    rst_n = 0;
    valid = 0;
    a = 0;
    // reset
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      chk("rst_y", y4, 4'b0000);
      chk("rst_ready", {3'b0, ready4}, 4'b0001);
    end
    rst_n = 1;
    step(0, 0);
    chk("post_rst_ready", {3'b0, ready4}, 4'b0001);
    chk("post_rst_busy", {3'b0, busy4}, 4'b0000);
    // single pulse a=2
    step(1, 2);
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      chk("pulse_y", y4, 4'b0100);
      chk("pulse_busy", {3'b0, busy4}, 4'b0001);
`ifdef DECODER_2X4_GAP_EN
      chk("pulse_ready", {3'b0, ready4}, 4'b0000);
`else
      chk("pulse_ready", {3'b0, ready4}, {3'b0, i == 3});
`endif
    end
    step(0, 0);
    chk("pulse_end_y", y4, 4'b0000);
    repeat (3) step(0, 0);
    // back-to-back via held valid
`ifdef DECODER_2X4_GAP_EN
    exp3 = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8};
`else
    exp3 = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h8, 4'h8, 4'h8, 4'h8, 4'h1, 4'h1};
`endif
    step(1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, i < 7 ? 2'd3 : 2'd0);
      chk("b2b_y", y4, exp3[i]);
    end
    repeat (8) step(0, 0);
    // input changes during DRIVE are ignored
    step(1, 1);
    step(0, 3); chk("ign_y", y4, 4'b0010);
    step(1, 3); chk("ign_y", y4, 4'b0010);
    step(0, 3); chk("ign_y", y4, 4'b0010);
    step(0, 0); chk("ign_y", y4, 4'b0010);
    step(0, 0); chk("ign_end_y", y4, 4'b0000);
    repeat (3) step(0, 0);
    // async reset in DRIVE cycle 2
    step(1, 3);
    step(0, 0);
    step(0, 0);
    chk("pre_arst_y", y4, 4'b1000);
    #1 rst_n = 0;
    #1;
    chk("arst_y", y4, 4'b0000);
    chk("arst_busy", {3'b0, busy4}, 4'b0000);
    step(0, 0);
    rst_n = 1;
    step(0, 0);
    chk("arst_ready", {3'b0, ready4}, 4'b0001);
    chk("arst_idle_y", y4, 4'b0000);
    // HOLD_CYCLES=1 stream
    step(1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 2'(i + 1));
`ifndef DECODER_2X4_GAP_EN
      chk("h1_y", y1, 4'(1 << i));
      chk("h1_ready", {3'b0, ready1}, 4'b0001);
`endif
    end
    step(0, 0);
    repeat (3) step(0, 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 6, 2'($urandom));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
    end
    step(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decoder_2x4_seq.md
Name: decoder_2x4_seq

Overview:
- Registered 2-to-4 decoder with a valid/ready handshake and a programmable output hold time.
- It is the receiving end of the 4x2 priority encoder link. It takes the encoded index `a` and the `valid` flag and drives the matching one-hot line on `y` for HOLD_CYCLES clocks.
- Used to re-expand encoded request or grant indices into one-hot strobes for downstream logic.

Parameters:
- HOLD_CYCLES, 4, number of clocks each accepted code drives `y`; legal range 1..255.
- CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  2  encoded index from the encoder.
- valid  input  1  `a` is meaningful; a transfer occurs on a rising edge where valid=1 and ready=1.
- ready  output  1  decoder can accept a code this cycle (combinational from state and counter).
- y  output  4  registered one-hot output; 4'b0000 when idle.
- busy  output  1  registered; 1 while `y` is non-zero.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, y=4'b0000, busy=0, counter=0, ready=1 while in IDLE. Reset asserted mid-operation clears `y` immediately, without waiting for a clock edge.
- State IDLE:
  - ready=1.
  - On accept: y <= 1<<a, busy <= 1, counter <= HOLD_CYCLES-1, next state DRIVE.
  - Latency from accept edge to `y` valid: 1 clock.
- State DRIVE:
  - `y` holds the one-hot value latched at accept.
  - Changes on `a` or `valid` are ignored except in the last cycle (see below).
  - counter decrements by 1 each clock while non-zero.
  - ready = (counter==0), i.e. only in the final drive cycle.
- Final DRIVE cycle (counter==0):
  - With a transfer: reload y <= 1<<a, counter <= HOLD_CYCLES-1, stay in DRIVE. The outputs are back-to-back with no zero cycle.
  - With no transfer: y <= 0, busy <= 0, next state IDLE.
- valid=1 while ready=0: not accepted and not stored. The source must hold `valid` and `a` until ready.
- HOLD_CYCLES=1: counter loads 0, so ready stays 1 every DRIVE cycle. A continuous valid stream produces one one-hot word per clock.
- `y` is always exactly one-hot or all-zero; never more than one bit set.
- Counter never wraps: it stops at 0, and loads only on accept.
- `busy` equals (y != 0) every cycle.

Optional Feature:
- Macro: DECODER_2X4_GAP_EN.
- Defined:
  - A third state GAP is added.
  - When the final DRIVE cycle ends, the block always enters GAP for exactly one clock: y=0, busy=0, ready=0.
  - It then moves to IDLE.
  - ready in DRIVE is forced to 0, so no transfer is taken in the final drive cycle.
  - Result: at least 2 zero clocks between consecutive one-hot outputs (GAP plus the IDLE accept cycle).
- Undefined: two states only; back-to-back reload in the final DRIVE cycle as described above.

Test Plan:
1. Hold rst_n=0 for 3 clocks, then release -> y=0000, busy=0, ready=1 throughout reset and after release.
2. HOLD_CYCLES=4, single pulse valid=1, a=2 at edge T0:
   - y=0100 and busy=1 at edges T0+1..T0+4.
   - ready=0 at T0+1..T0+3, ready=1 at T0+4.
   - y=0000 from T0+5.
3. HOLD_CYCLES=4, valid held high, a=0 and then a=3 presented at the final drive cycle:
   - Macro undefined -> y = 0001 x4, then 1000 x4, no zero cycle.
   - Macro defined -> 0001 x4, then 0000 x2, then 1000 x4.
4. HOLD_CYCLES=4, accept a=1, then toggle `a` to 3 and drop/raise `valid` during cycles 1-3 of DRIVE -> y stays 0010 for all 4 cycles; no extra transfer.
5. Accept a=3, drive rst_n=0 asynchronously in DRIVE cycle 2 -> y=0000 and busy=0 before the next clock edge; after release, ready=1 and state is IDLE.
6. HOLD_CYCLES=1, macro undefined, valid held high, `a` stepping 0,1,2,3 on consecutive edges -> y = 0001, 0010, 0100, 1000 on consecutive clocks; ready constantly 1.
